// File: rtl/uart_core.sv
// UART core with 16x oversampling: runtime baud divisor and parity mode,
// TX/RX FIFOs of 2^FIFO_W words, glitch-rejecting receiver, sticky error flags.
module uart_core #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DIV_BITS = 16,
  parameter int FIFO_W   = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [DIV_BITS-1:0] i_baud_div,
  input  logic [1:0]          i_parity_mode,
  input  logic                i_wr_uart,
  input  logic [DBIT-1:0]     i_w_data,
  output logic                o_tx_full,
  output logic                o_tx_busy,
  input  logic                i_rd_uart,
  output logic [DBIT-1:0]     o_r_data,
  output logic                o_rx_empty,
  output logic                o_parity_err,
  output logic                o_frame_err,
  output logic                o_overrun,
  input  logic                i_clr_err,
  input  logic                i_rx,
  output logic                o_tx
);

  localparam int DEPTH = 1 << FIFO_W;
  localparam logic [FIFO_W:0] FIFO_FULL = DEPTH[FIFO_W:0];
  localparam logic [3:0] DBIT_LAST = 4'(DBIT - 1);
  localparam logic [5:0] SB_LAST = 6'(SB_TICK - 1);
  localparam logic [5:0] TICK_LAST = 6'd15;
  localparam logic [5:0] START_MID = 6'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  logic [DIV_BITS-1:0] tick_cnt_q, tick_cnt_d, div_last;
  logic                tick;

  logic [DBIT-1:0]   txf_mem_q [DEPTH];
  logic [DBIT-1:0]   txf_mem_d [DEPTH];
  logic [FIFO_W-1:0] txf_wr_q, txf_wr_d, txf_rd_q, txf_rd_d;
  logic [FIFO_W:0]   txf_cnt_q, txf_cnt_d;
  logic              txf_empty, txf_full, txf_do_push, txf_do_pop;
  logic [DBIT-1:0]   txf_head;

  logic [DBIT-1:0]   rxf_mem_q [DEPTH];
  logic [DBIT-1:0]   rxf_mem_d [DEPTH];
  logic [FIFO_W-1:0] rxf_wr_q, rxf_wr_d, rxf_rd_q, rxf_rd_d;
  logic [FIFO_W:0]   rxf_cnt_q, rxf_cnt_d;
  logic              rxf_empty, rxf_full, rxf_do_push, rxf_do_pop;

  state_e          tx_state_q, tx_state_d;
  logic [5:0]      tx_s_q, tx_s_d;
  logic [3:0]      tx_n_q, tx_n_d;
  logic [DBIT-1:0] tx_b_q, tx_b_d;
  logic [1:0]      tx_pmode_q, tx_pmode_d;
  logic            tx_pbit_q, tx_pbit_d;
  logic            tx_q, tx_d;
  logic            tx_pop, tx_load;

  state_e          rx_state_q, rx_state_d;
  logic [5:0]      rx_s_q, rx_s_d;
  logic [3:0]      rx_n_q, rx_n_d;
  logic [DBIT-1:0] rx_b_q, rx_b_d;
  logic [1:0]      rx_pmode_q, rx_pmode_d;
  logic            rx_push, par_set, frame_set, overrun_set;

  logic parity_err_q, parity_err_d;
  logic frame_err_q, frame_err_d;
  logic overrun_q, overrun_d;

  // A zero divisor behaves like 1; >= lets a shrinking divisor tick at once.
  always_comb begin
    div_last   = (i_baud_div == '0) ? '0 : i_baud_div - 1'b1;
    tick       = (tick_cnt_q >= div_last);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  assign txf_empty = (txf_cnt_q == '0);
  assign txf_full  = (txf_cnt_q == FIFO_FULL);
  assign txf_head  = txf_mem_q[txf_rd_q];

  always_comb begin
    txf_do_pop  = tx_pop && !txf_empty;
    txf_do_push = i_wr_uart && (!txf_full || txf_do_pop);
    txf_mem_d   = txf_mem_q;
    txf_wr_d    = txf_wr_q;
    txf_rd_d    = txf_rd_q;
    txf_cnt_d   = txf_cnt_q;
    if (txf_do_push) begin
      txf_mem_d[txf_wr_q] = i_w_data;
      txf_wr_d            = txf_wr_q + 1'b1;
    end
    if (txf_do_pop) begin
      txf_rd_d = txf_rd_q + 1'b1;
    end
    case ({txf_do_push, txf_do_pop})
      2'b10:   txf_cnt_d = txf_cnt_q + 1'b1;
      2'b01:   txf_cnt_d = txf_cnt_q - 1'b1;
      default: txf_cnt_d = txf_cnt_q;
    endcase
  end

  assign rxf_empty = (rxf_cnt_q == '0);
  assign rxf_full  = (rxf_cnt_q == FIFO_FULL);

  always_comb begin
    rxf_do_pop  = i_rd_uart && !rxf_empty;
    rxf_do_push = rx_push && (!rxf_full || rxf_do_pop);
    rxf_mem_d   = rxf_mem_q;
    rxf_wr_d    = rxf_wr_q;
    rxf_rd_d    = rxf_rd_q;
    rxf_cnt_d   = rxf_cnt_q;
    if (rxf_do_push) begin
      rxf_mem_d[rxf_wr_q] = rx_b_d;
      rxf_wr_d            = rxf_wr_q + 1'b1;
    end
    if (rxf_do_pop) begin
      rxf_rd_d = rxf_rd_q + 1'b1;
    end
    case ({rxf_do_push, rxf_do_pop})
      2'b10:   rxf_cnt_d = rxf_cnt_q + 1'b1;
      2'b01:   rxf_cnt_d = rxf_cnt_q - 1'b1;
      default: rxf_cnt_d = rxf_cnt_q;
    endcase
  end

  // Loading a frame is shared by IDLE and end-of-STOP so frames run back to back.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_b_d     = tx_b_q;
    tx_pmode_d = tx_pmode_q;
    tx_pbit_d  = tx_pbit_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    tx_load    = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!txf_empty) begin
          tx_load = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tx_s_q == TICK_LAST) begin
            tx_s_d     = '0;
            tx_n_d     = '0;
            tx_state_d = ST_DATA;
            tx_d       = tx_b_q[0];
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tx_s_q == TICK_LAST) begin
            tx_s_d = '0;
            tx_b_d = tx_b_q >> 1;
            if (tx_n_q == DBIT_LAST) begin
              if (tx_pmode_q[0] ^ tx_pmode_q[1]) begin
                tx_state_d = ST_PARITY;
                tx_d       = tx_pbit_q;
              end else begin
                tx_state_d = ST_STOP;
                tx_d       = 1'b1;
              end
            end else begin
              tx_n_d = tx_n_q + 1'b1;
              tx_d   = tx_b_q[1];
            end
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (tx_s_q == TICK_LAST) begin
            tx_s_d     = '0;
            tx_state_d = ST_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tx_s_q == SB_LAST) begin
            if (!txf_empty) begin
              tx_load = 1'b1;
            end else begin
              tx_state_d = ST_IDLE;
              tx_d       = 1'b1;
            end
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
      default: begin
        tx_state_d = ST_IDLE;
        tx_d       = 1'b1;
      end
    endcase
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_b_d     = txf_head;
      tx_pmode_d = i_parity_mode;
      tx_pbit_d  = (^txf_head) ^ (i_parity_mode == 2'b10);
      tx_s_d     = '0;
      tx_state_d = ST_START;
      tx_d       = 1'b0;
    end
  end

  // Samples land at bit centres: start is re-checked 8 ticks in, then every 16.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_s_d     = rx_s_q;
    rx_n_d     = rx_n_q;
    rx_b_d     = rx_b_q;
    rx_pmode_d = rx_pmode_q;
    rx_push    = 1'b0;
    par_set    = 1'b0;
    frame_set  = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (tick && !i_rx) begin
          rx_state_d = ST_START;
          rx_s_d     = '0;
          rx_pmode_d = i_parity_mode;
        end
      end
      ST_START: begin
        if (tick) begin
          if (rx_s_q == START_MID) begin
            if (i_rx) begin
              rx_state_d = ST_IDLE;
            end else begin
              rx_state_d = ST_DATA;
              rx_s_d     = '0;
              rx_n_d     = '0;
            end
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (rx_s_q == TICK_LAST) begin
            rx_s_d = '0;
            rx_b_d = {i_rx, rx_b_q[DBIT-1:1]};
            if (rx_n_q == DBIT_LAST) begin
              rx_state_d = (rx_pmode_q[0] ^ rx_pmode_q[1]) ? ST_PARITY : ST_STOP;
            end else begin
              rx_n_d = rx_n_q + 1'b1;
            end
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (rx_s_q == TICK_LAST) begin
            rx_s_d     = '0;
            rx_state_d = ST_STOP;
            par_set    = ((^rx_b_q) ^ i_rx) != (rx_pmode_q == 2'b10);
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (rx_s_q == SB_LAST) begin
            rx_push    = 1'b1;
            frame_set  = !i_rx;
            rx_state_d = ST_IDLE;
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
      default: begin
        rx_state_d = ST_IDLE;
      end
    endcase
  end

  // A set in the same cycle as a clear wins.
  always_comb begin
    overrun_set  = rx_push && !rxf_do_push;
    parity_err_d = par_set     ? 1'b1 : (i_clr_err ? 1'b0 : parity_err_q);
    frame_err_d  = frame_set   ? 1'b1 : (i_clr_err ? 1'b0 : frame_err_q);
    overrun_d    = overrun_set ? 1'b1 : (i_clr_err ? 1'b0 : overrun_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tick_cnt_q   <= '0;
      txf_wr_q     <= '0;
      txf_rd_q     <= '0;
      txf_cnt_q    <= '0;
      rxf_wr_q     <= '0;
      rxf_rd_q     <= '0;
      rxf_cnt_q    <= '0;
      tx_state_q   <= ST_IDLE;
      tx_s_q       <= '0;
      tx_n_q       <= '0;
      tx_b_q       <= '0;
      tx_pmode_q   <= '0;
      tx_pbit_q    <= 1'b0;
      tx_q         <= 1'b1;
      rx_state_q   <= ST_IDLE;
      rx_s_q       <= '0;
      rx_n_q       <= '0;
      rx_b_q       <= '0;
      rx_pmode_q   <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      txf_wr_q     <= txf_wr_d;
      txf_rd_q     <= txf_rd_d;
      txf_cnt_q    <= txf_cnt_d;
      rxf_wr_q     <= rxf_wr_d;
      rxf_rd_q     <= rxf_rd_d;
      rxf_cnt_q    <= rxf_cnt_d;
      tx_state_q   <= tx_state_d;
      tx_s_q       <= tx_s_d;
      tx_n_q       <= tx_n_d;
      tx_b_q       <= tx_b_d;
      tx_pmode_q   <= tx_pmode_d;
      tx_pbit_q    <= tx_pbit_d;
      tx_q         <= tx_d;
      rx_state_q   <= rx_state_d;
      rx_s_q       <= rx_s_d;
      rx_n_q       <= rx_n_d;
      rx_b_q       <= rx_b_d;
      rx_pmode_q   <= rx_pmode_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Storage needs no reset: the counts alone decide what is valid.
  always_ff @(posedge i_clk) begin
    txf_mem_q <= txf_mem_d;
    rxf_mem_q <= rxf_mem_d;
  end

  assign o_tx         = tx_q;
  assign o_tx_full    = txf_full;
  assign o_tx_busy    = (tx_state_q != ST_IDLE) || !txf_empty;
  assign o_r_data     = rxf_mem_q[rxf_rd_q];
  assign o_rx_empty   = rxf_empty;
  assign o_parity_err = parity_err_q;
  assign o_frame_err  = frame_err_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: reset, start latency, loopback, parity,
// framing, overrun, TX full, glitch rejection and mid-frame reset.
module tb_uart_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        tx_full, tx_busy;
  logic        rd_uart;
  logic [7:0]  r_data;
  logic        rx_empty, parity_err, frame_err, overrun;
  logic        clr_err;
  logic        rx_line, tx;
  logic        loop_en, rx_drv;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_core #(.DBIT(8), .SB_TICK(16), .DIV_BITS(16), .FIFO_W(2)) dut (
    .i_clk(clk), .i_reset(reset), .i_baud_div(baud_div), .i_parity_mode(parity_mode),
    .i_wr_uart(wr_uart), .i_w_data(w_data), .o_tx_full(tx_full), .o_tx_busy(tx_busy),
    .i_rd_uart(rd_uart), .o_r_data(r_data), .o_rx_empty(rx_empty),
    .o_parity_err(parity_err), .o_frame_err(frame_err), .o_overrun(overrun),
    .i_clr_err(clr_err), .i_rx(rx_line), .o_tx(tx)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  task automatic pop();
    rd_uart = 1'b1;
    step();
    rd_uart = 1'b0;
  endtask

  // Drives one frame at div=1 (16 clocks per bit); clr_at / rd_at pulse the
  // matching input during that clock index of the frame (-1 for never).
  task automatic send_frame(input logic [7:0] data, input logic has_par, input logic par_bit,
                            input logic stop_bit, input int clr_at, input int rd_at);
    logic [10:0] fb;
    int nb;
    int k;
    fb = '1;
    fb[0] = 1'b0;
    fb[8:1] = data;
    if (has_par) begin
      fb[9] = par_bit;
      fb[10] = stop_bit;
      nb = 11;
    end else begin
      fb[9] = stop_bit;
      nb = 10;
    end
    k = 0;
    for (int i = 0; i < nb; i++) begin
      for (int t = 0; t < 16; t++) begin
        rx_drv = fb[i];
        clr_err = (k == clr_at);
        rd_uart = (k == rd_at);
        step();
        k++;
      end
    end
    rx_drv = 1'b1;
    clr_err = 1'b0;
    rd_uart = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (tx_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_full: got %b expected 0", tx_full); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_busy: got %b expected 0", tx_busy); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_rx_empty: got %b expected 1", rx_empty); end
    checks++; if ({parity_err, frame_err, overrun} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {parity_err, frame_err, overrun}); end
  endtask

  task automatic test_start_latency();
    baud_div = 16'd5;
    for (int ph = 0; ph < 3; ph++) begin
      do_reset();
      repeat (ph) step();
      w_data = 8'h5A;
      wr_uart = 1'b1;
      step();
      wr_uart = 1'b0;
      checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL latency_n1_ph%0d: got %b expected 1", ph, tx); end
      checks++; if (tx_busy !== 1'b1) begin errors++; $display("[TB] FAIL latency_busy_ph%0d: got %b expected 1", ph, tx_busy); end
      step();
      checks++; if (tx !== 1'b0) begin errors++; $display("[TB] FAIL latency_n2_ph%0d: got %b expected 0", ph, tx); end
    end
    baud_div = 16'd1;
    do_reset();
  endtask

  task automatic test_loopback();
    logic [7:0] exp_b [3];
    int c0;
    int d;
    exp_b[0] = 8'hA5;
    exp_b[1] = 8'h3C;
    exp_b[2] = 8'hFF;
    parity_mode = 2'b00;
    loop_en = 1'b1;
    w_data = 8'hA5;
    wr_uart = 1'b1;
    step();
    checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL loop_n1: got %b expected 1", tx); end
    w_data = 8'h3C;
    step();
    checks++; if (tx !== 1'b0) begin errors++; $display("[TB] FAIL loop_start: got %b expected 0", tx); end
    c0 = cyc;
    w_data = 8'hFF;
    step();
    wr_uart = 1'b0;
    while (cyc - c0 < 482) begin
      step();
      d = cyc - c0;
      if (d == 159) begin
        checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL loop_stop1: got %b expected 1", tx); end
      end
      if (d == 160) begin
        checks++; if (tx !== 1'b0) begin errors++; $display("[TB] FAIL loop_start2: got %b expected 0", tx); end
      end
      if (d == 320) begin
        checks++; if (tx !== 1'b0) begin errors++; $display("[TB] FAIL loop_start3: got %b expected 0", tx); end
      end
      if (d == 479) begin
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("[TB] FAIL loop_busy479: got %b expected 1", tx_busy); end
      end
      if (d == 480) begin
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL loop_busy480: got %b expected 0", tx_busy); end
      end
    end
    checks++; if ({parity_err, frame_err, overrun} !== 3'b000) begin errors++; $display("[TB] FAIL loop_flags: got %b expected 000", {parity_err, frame_err, overrun}); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rx_empty !== 1'b0 || r_data !== exp_b[i]) begin errors++; $display("[TB] FAIL loop_rx%0d: got empty=%b data=%h expected empty=0 data=%h", i, rx_empty, r_data, exp_b[i]); end
      pop();
    end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("[TB] FAIL loop_rx_drained: got %b expected 1", rx_empty); end
  endtask

  task automatic test_parity();
    int c0;
    int n;
    parity_mode = 2'b01;
    loop_en = 1'b1;
    w_data = 8'h07;
    wr_uart = 1'b1;
    step();
    wr_uart = 1'b0;
    step();
    c0 = cyc;
    while (cyc - c0 < 150) step();
    checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL par_line_bit: got %b expected 1", tx); end
    n = 0;
    while (rx_empty && n < 200) begin step(); n++; end
    checks++; if (rx_empty !== 1'b0 || r_data !== 8'h07) begin errors++; $display("[TB] FAIL par_loop_rx: got empty=%b data=%h expected empty=0 data=07", rx_empty, r_data); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL par_loop_err: got %b expected 0", parity_err); end
    pop();
    repeat (30) step();
    loop_en = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, -1, -1);
    step();
    checks++; if (parity_err !== 1'b1) begin errors++; $display("[TB] FAIL par_ext_err: got %b expected 1", parity_err); end
    checks++; if (rx_empty !== 1'b0 || r_data !== 8'h07) begin errors++; $display("[TB] FAIL par_ext_rx: got empty=%b data=%h expected empty=0 data=07", rx_empty, r_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL par_ext_frame: got %b expected 0", frame_err); end
    pop();
    clear_errs();
    checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL par_clear: got %b expected 0", parity_err); end
    parity_mode = 2'b00;
  endtask

  task automatic test_framing();
    parity_mode = 2'b00;
    loop_en = 1'b0;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1, -1);
    repeat (10) step();
    checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL frame_set: got %b expected 1", frame_err); end
    checks++; if (rx_empty !== 1'b0 || r_data !== 8'h55) begin errors++; $display("[TB] FAIL frame_rx: got empty=%b data=%h expected empty=0 data=55", rx_empty, r_data); end
    pop();
    clear_errs();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL frame_clear: got %b expected 0", frame_err); end
    repeat (10) step();
    // Stop bit is sampled at the 153rd edge of the frame: clear lands on it.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 152, -1);
    repeat (10) step();
    checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL frame_set_wins: got %b expected 1", frame_err); end
    pop();
    clear_errs();
    repeat (10) step();
  endtask

  task automatic test_overrun();
    loop_en = 1'b0;
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b0, 1'b0, 1'b1, -1, -1);
    step();
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set: got %b expected 1", overrun); end
    for (int b = 1; b <= 4; b++) begin
      checks++; if (rx_empty !== 1'b0 || r_data !== 8'(b)) begin errors++; $display("[TB] FAIL ovr_rx%0d: got empty=%b data=%h expected empty=0 data=%h", b, rx_empty, r_data, 8'(b)); end
      pop();
    end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("[TB] FAIL ovr_lost: got %b expected 1", rx_empty); end
    clear_errs();
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear: got %b expected 0", overrun); end
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b0, 1'b0, 1'b1, -1, -1);
    send_frame(8'h05, 1'b0, 1'b0, 1'b1, -1, 152);
    step();
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_popsame: got %b expected 0", overrun); end
    for (int b = 2; b <= 5; b++) begin
      checks++; if (rx_empty !== 1'b0 || r_data !== 8'(b)) begin errors++; $display("[TB] FAIL ovr_pop_rx%0d: got empty=%b data=%h expected empty=0 data=%h", b, rx_empty, r_data, 8'(b)); end
      pop();
    end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("[TB] FAIL ovr_pop_drained: got %b expected 1", rx_empty); end
  endtask

  task automatic test_tx_full();
    int idx;
    loop_en = 1'b1;
    parity_mode = 2'b00;
    for (int i = 0; i < 6; i++) begin
      w_data = 8'h10 + 8'(i);
      wr_uart = 1'b1;
      step();
      checks++; if (tx_full !== (i >= 4)) begin errors++; $display("[TB] FAIL txfull_push%0d: got %b expected %b", i, tx_full, (i >= 4)); end
      if (i == 1) begin
        checks++; if (tx !== 1'b0) begin errors++; $display("[TB] FAIL txfull_start: got %b expected 0", tx); end
      end
    end
    wr_uart = 1'b0;
    idx = 0;
    for (int n = 0; n < 1000; n++) begin
      if (!rx_empty) begin
        checks++;
        if (idx >= 5) begin
          errors++; $display("[TB] FAIL txfull_extra: got byte %h expected none", r_data);
        end else if (r_data !== 8'h10 + 8'(idx)) begin
          errors++; $display("[TB] FAIL txfull_rx%0d: got %h expected %h", idx, r_data, 8'h10 + 8'(idx));
        end
        idx++;
        pop();
      end else begin
        step();
      end
    end
    checks++; if (idx !== 5) begin errors++; $display("[TB] FAIL txfull_count: got %0d expected 5", idx); end
    checks++; if (tx_busy !== 1'b0 || overrun !== 1'b0) begin errors++; $display("[TB] FAIL txfull_end: got busy=%b ovr=%b expected 0 0", tx_busy, overrun); end
  endtask

  task automatic test_glitch();
    loop_en = 1'b0;
    rx_drv = 1'b0;
    repeat (4) step();
    rx_drv = 1'b1;
    repeat (100) step();
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("[TB] FAIL glitch_rx: got %b expected 1", rx_empty); end
    checks++; if ({parity_err, frame_err} !== 2'b00) begin errors++; $display("[TB] FAIL glitch_flags: got %b expected 00", {parity_err, frame_err}); end
  endtask

  task automatic test_reset_mid();
    int c0;
    int bad;
    loop_en = 1'b1;
    w_data = 8'hAA;
    wr_uart = 1'b1;
    step();
    w_data = 8'h55;
    step();
    wr_uart = 1'b0;
    c0 = cyc;
    while (cyc - c0 < 50) step();
    checks++; if (tx !== 1'b0 || tx_busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre: got tx=%b busy=%b expected 0 1", tx, tx_busy); end
    reset = 1'b1;
    step();
    checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL rst_tx: got %b expected 1", tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", tx_busy); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("[TB] FAIL rst_rx_empty: got %b expected 1", rx_empty); end
    reset = 1'b0;
    bad = 0;
    repeat (400) begin
      step();
      if (tx !== 1'b1 || rx_empty !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL rst_quiet: got %0d active cycles expected 0", bad); end
  endtask

  initial begin
    reset = 1'b1;
    baud_div = 16'd1;
    parity_mode = 2'b00;
    wr_uart = 1'b0;
    w_data = 8'h00;
    rd_uart = 1'b0;
    clr_err = 1'b0;
    loop_en = 1'b0;
    rx_drv = 1'b1;
    test_reset();
    test_start_latency();
    test_loopback();
    test_parity();
    test_framing();
    test_overrun();
    test_tx_full();
    test_glitch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Next-generation parametrised UART core: runtime baud divisor, runtime parity mode, TX FIFO and RX FIFO of depth 2^FIFO_W, glitch-rejecting receiver, and sticky parity, framing and overrun error flags.
- Sits between the i_rx/o_tx pins and a byte-stream client (command interface or ALU front end) that uses push/pop FIFO handshakes.
- 16x oversampling throughout.

Parameters:
- DBIT, 8: data bits per frame; legal range 5..9.
- SB_TICK, 16: stop-bit length in ticks; 16, 24 or 32 give 1, 1.5 or 2 stop bits.
- DIV_BITS, 16: width of i_baud_div.
- FIFO_W, 2: FIFO address bits; each FIFO holds 2^FIFO_W words.

Ports:
- i_clk  in  1  single clock.
- i_reset  in  1  synchronous, active-high reset.
- i_baud_div  in  DIV_BITS  tick period in clocks (50 MHz / (16 × baud)); 0 is treated as 1.
- i_parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
- i_wr_uart  in  1  push i_w_data into TX FIFO.
- i_w_data  in  DBIT  TX byte.
- o_tx_full  out  1  TX FIFO full.
- o_tx_busy  out  1  TX FSM not idle, or TX FIFO not empty.
- i_rd_uart  in  1  pop RX FIFO.
- o_r_data  out  DBIT  RX FIFO head (first-word fall-through).
- o_rx_empty  out  1  RX FIFO empty.
- o_parity_err  out  1  sticky parity error.
- o_frame_err  out  1  sticky framing error.
- o_overrun  out  1  sticky RX overrun.
- i_clr_err  in  1  clears all three sticky flags.
- i_rx  in  1  serial input; already synchronised externally.
- o_tx  out  1  serial output; registered.

Behaviour:
- Reset values: o_tx=1, o_tx_full=0, o_tx_busy=0, o_rx_empty=1, all error flags 0, both FIFOs empty, both FSMs IDLE, tick counter 0. o_r_data is valid only while o_rx_empty=0.
- Reset mid-frame: the frame is abandoned, o_tx=1 on the next cycle, and FIFO contents are discarded.
- Tick generator: counter counts 0..div-1; one-cycle tick when count ≥ div-1, then returns to 0. A divisor change takes effect within one tick period. div=1 gives a tick every clock.
- i_parity_mode is sampled at frame start (leaving IDLE) and held for the whole frame.
- FIFOs:
  - Write when full is ignored; read when empty is ignored.
  - Simultaneous push and pop succeed on a full FIFO and leave the count unchanged.
  - Simultaneous push and pop on an empty FIFO: the push succeeds and the pop is ignored.
  - Pointers wrap modulo 2^FIFO_W; full and empty are decided by a count register or an extra pointer bit.
- TX FSM states: IDLE → START → DATA → PARITY (only if parity enabled) → STOP → IDLE.
  - IDLE: if the TX FIFO is non-empty, pop the head and load the shift register.
  - A push at cycle N into an empty FIFO with the FSM idle drives o_tx=0 at cycle N+2, independent of tick phase.
  - Bit durations: start bit 16 ticks, each data bit 16 ticks (LSB first), parity bit 16 ticks, stop SB_TICK ticks at o_tx=1.
  - Parity bit: even mode makes the total count of 1s (data + parity) even; odd mode makes it odd.
  - Back-to-back frames: the next START follows STOP with no idle gap.
- RX FSM states: IDLE → START → DATA → PARITY (only if parity enabled) → STOP → IDLE.
  - IDLE: i_rx=0 on a tick enters START.
  - START: after 7 ticks re-sample i_rx. If 1, the start bit was a glitch: return to IDLE, no push.
  - DATA: sample every 16 ticks at bit centre, LSB first, DBIT bits.
  - PARITY: sample at centre; a mismatch sets o_parity_err.
  - STOP: sample after SB_TICK ticks. i_rx=0 sets o_frame_err.
  - At the end of STOP, push the byte even when an error was flagged. If the RX FIFO is full (and not popped that same cycle), drop the byte and set o_overrun.
- Sticky flags: i_clr_err clears them. If a flag set and i_clr_err occur in the same cycle, the set wins.

Test Plan:
- Loopback (o_tx→i_rx), div=1, no parity, DBIT=8: push 0xA5, 0x3C, 0xFF → RX pops 0xA5, 0x3C, 0xFF in order; no error flags; each frame is 160 clocks; o_tx_busy falls 480 clocks after the first START.
- Even parity, loopback: push 0x07 → line parity bit=1 and no error. Then drive an external frame 0x07 with parity bit 0 → o_parity_err=1 and 0x07 is still readable.
- Framing: drive frame 0x55 with stop bit 0 → o_frame_err=1 and 0x55 is pushed. Pulse i_clr_err → flag returns to 0. Set and clear in the same cycle → flag stays 1.
- Overrun, FIFO_W=2: receive 0x01..0x05 with no reads → pops return 0x01..0x04, o_overrun=1, 0x05 lost. A pop in the same cycle as the 5th push instead stores 0x05 with no overrun.
- TX full: push 0x10..0x15 on six consecutive cycles while idle → 0x10 is popped at cycle 1, o_tx_full=1 after cycle 4, 0x15 is dropped; the line carries 0x10..0x14.
- Glitch and reset: i_rx low for 4 ticks → no byte, o_rx_empty stays 1. Assert i_reset during TX DATA of 0xAA → o_tx=1 next cycle, o_tx_busy=0, o_rx_empty=1, no further frames.
